// File: rtl/pfb_tap_accumulator.sv
// Polyphase filter bank tap accumulator: sums TAPS signed products per branch,
// then rounds, rescales and saturates each sum to a signed OUT_WIDTH sample.
module pfb_tap_accumulator #(
  parameter int TAPS       = 8,
  parameter int PROD_WIDTH = 31,
  parameter int ACC_WIDTH  = 34,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [PROD_WIDTH-1:0] s_prod_tdata,
  input  logic                         s_prod_tvalid,
  output logic                         s_prod_tready,
  input  logic                         s_prod_tlast,
  output logic signed [OUT_WIDTH-1:0]  m_out_tdata,
  output logic                         m_out_tvalid,
  input  logic                         m_out_tready,
  output logic                         m_out_tlast,
  output logic                         sat_flag,
  output logic                         align_err
);

  localparam int CNT_W = $clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // One guard bit above the accumulator so the rounding bias cannot wrap a full-scale sum.
  localparam int RND_W = ACC_WIDTH + 1;
  localparam logic signed [RND_W-1:0] RND_BIAS =
    {{(RND_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [RND_W-1:0] OUT_MAX =
    {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] OUT_MIN =
    {{(RND_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  if ((TAPS < 2) || (TAPS > 64) || ((TAPS & (TAPS - 1)) != 0)) begin : g_bad_taps
    $error("pfb_tap_accumulator: TAPS must be a power of two in 2..64");
  end
  if (ACC_WIDTH < PROD_WIDTH + $clog2(TAPS)) begin : g_bad_acc
    $error("pfb_tap_accumulator: ACC_WIDTH too small for TAPS products");
  end
  if ((SHIFT < 1) || (SHIFT >= ACC_WIDTH) || (OUT_WIDTH >= RND_W - SHIFT)) begin : g_bad_shift
    $error("pfb_tap_accumulator: SHIFT/OUT_WIDTH out of range");
  end

  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
    input logic signed [PROD_WIDTH-1:0] p
  );
    return {{(ACC_WIDTH-PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
  endfunction

  // Round half up toward +inf, then arithmetic rescale.
  function automatic logic signed [RND_W-1:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] f
  );
    logic signed [RND_W-1:0] biased;
    biased = $signed({f[ACC_WIDTH-1], f}) + RND_BIAS;
    return biased >>> SHIFT;
  endfunction

  function automatic logic needs_clamp(input logic signed [RND_W-1:0] r);
    return (r > OUT_MAX) || (r < OUT_MIN);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] clamp(input logic signed [RND_W-1:0] r);
    logic signed [RND_W-1:0] c;
    if (r > OUT_MAX) begin
      c = OUT_MAX;
    end else if (r < OUT_MIN) begin
      c = OUT_MIN;
    end else begin
      c = r;
    end
    return c[OUT_WIDTH-1:0];
  endfunction

  logic [CNT_W-1:0]            tap_cnt;
  logic signed [ACC_WIDTH-1:0] acc;

  logic                        accept;
  logic                        last_tap;
  logic                        misalign;
  logic                        emit;
  logic signed [ACC_WIDTH-1:0] sum_base;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [RND_W-1:0]     rounded;
  logic [CNT_W-1:0]            tap_cnt_next;
  logic signed [ACC_WIDTH-1:0] acc_next;

  // Input stalls only while an unaccepted output is held.
  always_comb begin
    s_prod_tready = !(m_out_tvalid && !m_out_tready);
  end

  // Accumulate path, tap counting and misalignment recovery.
  always_comb begin
    accept       = s_prod_tvalid && s_prod_tready;
    last_tap     = (tap_cnt == LAST_TAP);
    misalign     = accept && s_prod_tlast && !last_tap;
    emit         = accept && last_tap;
    sum_base     = {ACC_WIDTH{1'b0}};
    sum          = {ACC_WIDTH{1'b0}};
    rounded      = {RND_W{1'b0}};
    tap_cnt_next = tap_cnt;
    acc_next     = acc;

    if (tap_cnt == {CNT_W{1'b0}}) begin
      sum_base = {ACC_WIDTH{1'b0}};
    end else begin
      sum_base = acc;
    end
    sum     = sum_base + sext_prod(s_prod_tdata);
    rounded = round_shift(sum);

    if (!accept) begin
      tap_cnt_next = tap_cnt;
      acc_next     = acc;
    end else if (misalign) begin
      // Partial sum is dropped; the next product starts a fresh block.
      tap_cnt_next = {CNT_W{1'b0}};
      acc_next     = {ACC_WIDTH{1'b0}};
    end else if (last_tap) begin
      tap_cnt_next = {CNT_W{1'b0}};
      acc_next     = sum;
    end else begin
      tap_cnt_next = tap_cnt + CNT_ONE;
      acc_next     = sum;
    end
  end

  // Accumulator state and tap counter.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      tap_cnt <= {CNT_W{1'b0}};
      acc     <= {ACC_WIDTH{1'b0}};
    end else begin
      tap_cnt <= tap_cnt_next;
      acc     <= acc_next;
    end
  end

  // Output register: a new sample may load in the same cycle the old one drains.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      m_out_tdata  <= {OUT_WIDTH{1'b0}};
      m_out_tvalid <= 1'b0;
      m_out_tlast  <= 1'b0;
    end else if (emit) begin
      m_out_tdata  <= clamp(rounded);
      m_out_tvalid <= 1'b1;
      m_out_tlast  <= s_prod_tlast;
    end else if (m_out_tvalid && m_out_tready) begin
      m_out_tvalid <= 1'b0;
    end else begin
      m_out_tvalid <= m_out_tvalid;
    end
  end

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      sat_flag  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      sat_flag  <= sat_flag  | (emit && needs_clamp(rounded));
      align_err <= align_err | misalign;
    end
  end

endmodule

// File: tb/tb_pfb_tap_accumulator.sv
// Scoreboard bench for pfb_tap_accumulator: directed product blocks push expected
// samples; a monitor pops and compares on every output handshake.
module tb_pfb_tap_accumulator;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic signed [30:0] s_prod_tdata;
  logic               s_prod_tvalid;
  logic               s_prod_tready;
  logic               s_prod_tlast;
  logic signed [15:0] m_out_tdata;
  logic               m_out_tvalid;
  logic               m_out_tready;
  logic               m_out_tlast;
  logic               sat_flag;
  logic               align_err;

  always #5 ap_clk = ~ap_clk;

  pfb_tap_accumulator #(
    .TAPS(8), .PROD_WIDTH(31), .ACC_WIDTH(34), .OUT_WIDTH(16), .SHIFT(15)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_prod_tdata(s_prod_tdata), .s_prod_tvalid(s_prod_tvalid),
    .s_prod_tready(s_prod_tready), .s_prod_tlast(s_prod_tlast),
    .m_out_tdata(m_out_tdata), .m_out_tvalid(m_out_tvalid),
    .m_out_tready(m_out_tready), .m_out_tlast(m_out_tlast),
    .sat_flag(sat_flag), .align_err(align_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;
  int n_stall  = 0;
  int exp_data_q[$];
  bit exp_last_q[$];

  bit                 held = 1'b0;
  logic signed [15:0] held_data;
  logic               held_last;
  int                 mon_data;
  bit                 mon_last;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare each output handshake against the scoreboard; also verify hold stability.
  always @(negedge ap_clk) begin
    if (ap_rst_n === 1'b1) begin
      if (held) begin
        check("held_data", m_out_tdata, held_data);
        check("held_last", m_out_tlast, held_last);
      end
      if (m_out_tvalid && m_out_tready) begin
        if (exp_data_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d, expected no output", m_out_tdata);
        end else begin
          mon_data = exp_data_q.pop_front();
          mon_last = exp_last_q.pop_front();
          check("out_data", m_out_tdata, mon_data);
          check("out_last", m_out_tlast, mon_last);
        end
      end
      held      = m_out_tvalid && !m_out_tready;
      held_data = m_out_tdata;
      held_last = m_out_tlast;
      if (s_prod_tvalid && s_prod_tready) n_accept++;
      if (s_prod_tvalid && !s_prod_tready) n_stall++;
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input longint d, input bit l);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    s_prod_tdata  = 31'(d);
    s_prod_tlast  = l;
    s_prod_tvalid = 1'b1;
    while (!done && guard < 200) begin
      @(negedge ap_clk);
      done = s_prod_tready;
      @(posedge ap_clk);
      #1;
      guard++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no ready in %0d cycles, expected ready", guard);
    end
  endtask

  task automatic idle();
    s_prod_tvalid = 1'b0;
    s_prod_tlast  = 1'b0;
    s_prod_tdata  = 31'sd0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic send_block(input longint first, input longint rest, input bit last, input int exp);
    exp_data_q.push_back(exp);
    exp_last_q.push_back(last);
    send(first, 1'b0);
    for (int i = 1; i < 8; i++) send(rest, last && (i == 7));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tdata"}, m_out_tdata, 0);
    check({tag, "_tvalid"}, m_out_tvalid, 0);
    check({tag, "_tlast"}, m_out_tlast, 0);
    check({tag, "_sat"}, sat_flag, 0);
    check({tag, "_align"}, align_err, 0);
    check({tag, "_tready"}, s_prod_tready, 1);
  endtask

  initial begin
    int guard;
    ap_rst_n     = 1'b0;
    m_out_tready = 1'b1;
    idle();
    cycles(3);
    ap_rst_n = 1'b1;
    check_reset_state("reset");

    // Unity-ish gain block and output latency.
    exp_data_q.push_back(8);
    exp_last_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) send(32768, 1'b0);
    check("valid_before_last_tap", m_out_tvalid, 0);
    send(32768, 1'b1);
    check("valid_after_last_tap", m_out_tvalid, 1);
    idle();
    cycles(2);
    check("valid_one_cycle", m_out_tvalid, 0);
    check("sat_after_normal", sat_flag, 0);

    // Rounding at the half-LSB boundaries.
    send_block(16384, 0, 1'b1, 1);
    send_block(-16385, 0, 1'b1, -1);
    send_block(-16384, 0, 1'b1, 0);
    idle();
    cycles(2);
    check("sat_after_rounding", sat_flag, 0);

    // Saturation at both rails.
    send_block(1073741823, 1073741823, 1'b1, 32767);
    idle();
    cycles(2);
    check("sat_positive", sat_flag, 1);
    send_block(-1073741824, -1073741824, 1'b1, -32768);
    idle();
    cycles(3);

    // Backpressure: three blocks while downstream is stalled for 20 cycles.
    n_accept = 0;
    n_stall  = 0;
    m_out_tready = 1'b0;
    fork
      begin
        repeat (20) @(posedge ap_clk);
        #1;
        m_out_tready = 1'b1;
      end
      begin
        send_block(32768, 32768, 1'b0, 8);
        send_block(65536, 65536, 1'b0, 16);
        send_block(98304, 98304, 1'b1, 24);
      end
    join
    idle();
    cycles(4);
    check("bp_accepted", n_accept, 24);
    check("bp_ready_dropped", (n_stall > 0) ? 1 : 0, 1);

    // Misaligned tlast on the fifth product drops the partial sum.
    for (int i = 0; i < 4; i++) send(32768, 1'b0);
    send(32768, 1'b1);
    idle();
    cycles(3);
    check("align_err_set", align_err, 1);
    check("misalign_no_output", m_out_tvalid, 0);
    send_block(32768, 32768, 1'b1, 8);
    idle();
    cycles(3);

    // Reset in the middle of a block.
    for (int i = 0; i < 4; i++) send(32768, 1'b0);
    idle();
    ap_rst_n = 1'b0;
    cycles(1);
    ap_rst_n = 1'b1;
    check_reset_state("midreset");
    send_block(16384, 16384, 1'b1, 4);
    idle();

    guard = 0;
    while (exp_data_q.size() != 0 && guard < 100) begin
      cycles(1);
      guard++;
    end
    check("scoreboard_drained", exp_data_q.size(), 0);
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
